vec_mac_sequencer: RTL and testbench
====================================

// Module: vec_mac_sequencer
// PURPOSE
// - Driver side of the vector integer MAC interface. Accepts operand vector beats (a,b) over valid/ready.
// - Issues each beat to an external VECTOR-lane registered MAC, feeding the running accumulator back as c.
// - Captures c_ab after the MAC latency; after the beat flagged last, presents the K-beat dot product downstream.
// - Sits between the operand buffer and the result writeback; the MAC instance lives in the parent.
// PARAMETERS
// - REG_WIDTH  16  lane width of a, b, c and result
// - VECTOR     8   number of lanes
// - MAC_LAT    1   MAC pipeline depth in clocks (c_ab valid MAC_LAT cycles after issue); legal range 1..4
// - CNT_W      8   beat-counter width
// PORTS
// - clk        in   1                 clock; all flops on rising edge
// - rst_n      in   1                 asynchronous active-low reset
// - in_valid   in   1                 operand beat valid
// - in_ready   out  1                 sequencer can accept a beat
// - in_a       in   REG_WIDTH x VECTOR  operand a lanes
// - in_b       in   REG_WIDTH x VECTOR  operand b lanes
// - in_last    in   1                 beat closes the current accumulation
// - in_bias    in   REG_WIDTH x VECTOR  initial c (present only with VMAC_BIAS_EN)
// - mac_a      out  REG_WIDTH x VECTOR  to MAC a_n_1
// - mac_b      out  REG_WIDTH x VECTOR  to MAC b_n_1
// - mac_c      out  REG_WIDTH x VECTOR  to MAC c_n_1 (= accumulator)
// - mac_c_ab   in   REG_WIDTH x VECTOR  from MAC c_ab
// - out_valid  out  1                 result valid
// - out_ready  in   1                 downstream accepts result
// - out_c      out  REG_WIDTH x VECTOR  accumulated result
// - out_beats  out  CNT_W             beats in this result, saturating
// BEHAVIOUR
// - Interface: one clock, clk; reset asynchronous active-low, rst_n.
// - Reset: state=IDLE; in_ready=0 during reset, 1 in the first cycle after release.
// - Reset: out_valid=0; mac_a/mac_b/mac_c, out_c, out_beats and the accumulator all 0.
// - Reset mid-operation discards the partial accumulation; no result is emitted.
// - FSM IDLE: in_ready=1; in_valid&in_ready latches a,b,last into op regs.
// -   IDLE -> ISSUE. On the first beat of an accumulation, acc is loaded with 0 (or in_bias).
// - FSM ISSUE (1 cycle): mac_a/mac_b=op regs, mac_c=acc; in_ready=0; -> WAIT.
// - FSM WAIT (MAC_LAT cycles, down-counter): mac ports held stable.
// -   Last WAIT cycle: acc<=mac_c_ab; beat count increments, saturating at 2^CNT_W-1.
// -   Last WAIT cycle: -> DONE if last, else -> IDLE.
// - FSM DONE: out_valid=1; out_c=acc, out_beats=count; held stable until out_ready.
// -   out_valid&out_ready -> IDLE; count cleared; next beat starts a fresh accumulation.
// - in_ready is 1 only in IDLE. No beat is accepted while a result is pending.
// - Throughput: 1 beat per MAC_LAT+2 cycles.
// - Arithmetic: the MAC computes a*b+c truncated to REG_WIDTH, so wrap-around modulo 2^REG_WIDTH is required behaviour.
// - Arithmetic: the sequencer never extends or saturates data.
// - Edge case: in_last on the first beat gives a single product (+bias).
// - Edge case: in_valid held high in DONE is ignored until the return to IDLE.
// - Edge case: out_ready high before DONE has no effect.
// CONFIGURATION
// - VMAC_BIAS_EN defined: in_bias port exists; the first beat loads acc<=in_bias at acceptance.
// - VMAC_BIAS_EN undefined: port absent; the first beat loads acc<=0.
// STRUCTURE
// - Shared package vec_mac_pkg:
// -   state enum {IDLE,ISSUE,WAIT,DONE}
// -   typedef lane_t = logic [REG_WIDTH-1:0]
// -   localparam MAC_LAT_MAX=4
// - Natural sub-module: vmac_lat_cnt, the MAC_LAT down-counter that asserts 'capture'.
// - The accumulator and op regs stay in the top.
// TESTING
// - Bench instantiates vector_MAC_int (latency 1) as the MAC model; VECTOR=8, REG_WIDTH=16.
// - Single beat: a=all 3, b=all 4, last=1 -> out_c=all 12, out_beats=1, out_valid 3 cycles after accept.
// - 4 beats: a=lane index, b=2, last on beat 4 -> out_c[j]=8*j, out_beats=4; in_ready low during ISSUE/WAIT.
// - Wrap: a=16'h8000, b=2, 2 beats -> out_c=0 (mod 2^16).
// - Backpressure: out_ready=0 for 10 cycles -> out_c stable, in_ready=0; then release -> IDLE next cycle.
// - Reset mid-op: assert rst_n=0 in WAIT of beat 2 -> outputs 0 at once; a new 1-beat run gives a clean result.
// - VMAC_BIAS_EN: bias=all 5, a=b=all 1, 1 beat -> out_c=all 6; without macro -> all 1.

Source files
------------

// File: rtl/vec_mac_pkg.sv
// vec_mac_pkg: shared types and limits for the vector MAC sequencer.
// Holds the FSM state enum, the lane type and the MAC latency ceiling.
package vec_mac_pkg;

  localparam int REG_WIDTH   = 16;
  localparam int VECTOR      = 8;
  localparam int MAC_LAT_MAX = 4;

  typedef logic [REG_WIDTH-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/vec_mac_sequencer_if.sv
// vec_mac_sequencer_if: operand, MAC and result bundles of the sequencer.
// slave = sequencer side, master = buffer/MAC/writeback side.
// in_bias exists only when VMAC_BIAS_EN is defined.
interface vec_mac_sequencer_if #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 8,
  parameter int CNT_W     = 8
);

  typedef logic [VECTOR-1:0][REG_WIDTH-1:0] vec_t;

  logic       in_valid;
  logic       in_ready;
  vec_t       in_a;
  vec_t       in_b;
  logic       in_last;
`ifdef VMAC_BIAS_EN
  vec_t       in_bias;
`endif
  vec_t       mac_a;
  vec_t       mac_b;
  vec_t       mac_c;
  vec_t       mac_c_ab;
  logic       out_valid;
  logic       out_ready;
  vec_t       out_c;
  logic [CNT_W-1:0] out_beats;

  modport slave (
    input  in_valid,
`ifdef VMAC_BIAS_EN
    input  in_bias,
`endif
    input  in_a,
    input  in_b,
    input  in_last,
    input  mac_c_ab,
    input  out_ready,
    output in_ready,
    output mac_a,
    output mac_b,
    output mac_c,
    output out_valid,
    output out_c,
    output out_beats
  );

  modport master (
    output in_valid,
`ifdef VMAC_BIAS_EN
    output in_bias,
`endif
    output in_a,
    output in_b,
    output in_last,
    output mac_c_ab,
    output out_ready,
    input  in_ready,
    input  mac_a,
    input  mac_b,
    input  mac_c,
    input  out_valid,
    input  out_c,
    input  out_beats
  );

endinterface

// File: rtl/vec_mac_sequencer_lat_cnt.sv
// vmac_lat_cnt: MAC latency down-counter; capture marks the last WAIT cycle.
// Ports: clk, rst_n, load (ISSUE), en (WAIT), capture (out).
module vmac_lat_cnt
  import vec_mac_pkg::*;
#(
  parameter int MAC_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic capture
);

  localparam int CW = $clog2(MAC_LAT_MAX);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MAC_LAT - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign capture = en && (cnt == '0);

endmodule

// File: rtl/vec_mac_sequencer.sv
// vec_mac_sequencer: drives an external registered vector MAC, accumulating
// K operand beats into a dot product presented on a valid/ready result port.
// Ports: clk, rst_n (async, active low), bus (vec_mac_sequencer_if.slave):
//   in_* operand beat handshake, mac_* MAC issue/return, out_* result.
// Option: VMAC_BIAS_EN adds in_bias, loaded as the initial accumulator.
module vec_mac_sequencer
  import vec_mac_pkg::*;
#(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 8,
  parameter int MAC_LAT   = 1,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  vec_mac_sequencer_if.slave bus
);

  typedef logic [VECTOR-1:0][REG_WIDTH-1:0] vec_t;

  state_t state;
  state_t state_nx;

  vec_t             op_a;
  vec_t             op_b;
  vec_t             acc;
  vec_t             acc_init;
  logic             op_last;
  logic [CNT_W-1:0] beats;

  logic accept;
  logic load;
  logic capture;
  logic done_hs;

`ifdef VMAC_BIAS_EN
  assign acc_init = bus.in_bias;
`else
  assign acc_init = '0;
`endif

  // in_ready gated by rst_n so it stays low while reset is held
  assign bus.in_ready  = (state == IDLE) & rst_n;
  assign bus.out_valid = (state == DONE);
  assign accept        = bus.in_valid & bus.in_ready;
  assign done_hs       = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = ISSUE;
      end
      ISSUE: begin
        load     = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (capture) state_nx = op_last ? DONE : IDLE;
      end
      DONE: begin
        if (done_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  vmac_lat_cnt #(
    .MAC_LAT (MAC_LAT)
  ) u_lat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .en      (state == WAIT),
    .capture (capture)
  );

  // beats==0 marks the first beat of a fresh accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      op_last <= 1'b0;
      acc     <= '0;
      beats   <= '0;
    end else begin
      if (accept) begin
        op_a    <= bus.in_a;
        op_b    <= bus.in_b;
        op_last <= bus.in_last;
        if (beats == '0) acc <= acc_init;
      end
      if (capture) begin
        acc <= bus.mac_c_ab;
        if (beats != '1) beats <= beats + 1'b1;
      end
      if (done_hs) beats <= '0;
    end
  end

  assign bus.mac_a     = op_a;
  assign bus.mac_b     = op_b;
  assign bus.mac_c     = acc;
  assign bus.out_c     = acc;
  assign bus.out_beats = beats;

endmodule

// File: tb/tb_vec_mac_sequencer.sv
// tb_vec_mac_sequencer: directed vectors for vec_mac_sequencer with an
// inline latency-1 vector MAC model standing in for vector_MAC_int.
module tb_vec_mac_sequencer;
  import vec_mac_pkg::*;

  typedef logic [7:0][15:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vec_mac_sequencer_if #(
    .REG_WIDTH (16),
    .VECTOR    (8),
    .CNT_W     (8)
  ) bus ();

  vec_mac_sequencer #(
    .REG_WIDTH (16),
    .VECTOR    (8),
    .MAC_LAT   (1),
    .CNT_W     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // registered MAC: c_ab = a*b + c, truncated per lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mac_c_ab <= '0;
    end else begin
      for (int j = 0; j < 8; j++) begin
        bus.mac_c_ab[j] <= lane_t'(bus.mac_a[j] * bus.mac_b[j] + bus.mac_c[j]);
      end
    end
  end

  function automatic vec_t fill(input logic [15:0] v);
    vec_t f;
    for (int j = 0; j < 8; j++) f[j] = v;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input vec_t a, input vec_t b, input logic last);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("rdy_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) chk("out_timeout", 0, 1);
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("pop_rdy", 128'(bus.in_ready), 1);
    chk("pop_vld", 128'(bus.out_valid), 0);
  endtask

  initial begin
    int   lat;
    vec_t idx;
    vec_t exp4;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef VMAC_BIAS_EN
    bus.in_bias   = '0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",   128'(bus.in_ready), 0);
    chk("rst_vld",   128'(bus.out_valid), 0);
    chk("rst_outc",  bus.out_c, 0);
    chk("rst_beats", 128'(bus.out_beats), 0);
    chk("rst_maca",  bus.mac_a, 0);
    chk("rst_macc",  bus.mac_c, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", 128'(bus.in_ready), 1);
    @(posedge clk); #1;

    // single beat 3*4
    send_beat(fill(3), fill(4), 1'b1);
    chk("s_issue_rdy", 128'(bus.in_ready), 0);
    chk("s_issue_vld", 128'(bus.out_valid), 0);
    wait_out(lat);
    chk("s_lat",   128'(lat), 3);
    chk("s_outc",  bus.out_c, fill(12));
    chk("s_beats", 128'(bus.out_beats), 1);
    pop();

    // four beats, a=lane index, b=2
    for (int j = 0; j < 8; j++) begin
      idx[j]  = 16'(j);
      exp4[j] = 16'(8 * j);
    end
    for (int i = 0; i < 4; i++) begin
      send_beat(idx, fill(2), i == 3);
      if (i == 0) begin
        chk("m_issue_rdy", 128'(bus.in_ready), 0);
        @(posedge clk); #1;
        chk("m_wait_rdy", 128'(bus.in_ready), 0);
        chk("m_wait_vld", 128'(bus.out_valid), 0);
      end
    end
    wait_out(lat);
    chk("m_outc",  bus.out_c, exp4);
    chk("m_beats", 128'(bus.out_beats), 4);
    pop();

    // wrap-around: 0x8000*2 twice
    send_beat(fill(16'h8000), fill(2), 1'b0);
    send_beat(fill(16'h8000), fill(2), 1'b1);
    wait_out(lat);
    chk("w_outc",  bus.out_c, 0);
    chk("w_beats", 128'(bus.out_beats), 2);
    pop();

    // backpressure with in_valid held high in DONE
    send_beat(fill(5), fill(5), 1'b1);
    wait_out(lat);
    bus.in_valid = 1'b1;
    bus.in_a     = fill(9);
    bus.in_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_outc", bus.out_c, fill(25));
      chk("bp_rdy",  128'(bus.in_ready), 0);
    end
    chk("bp_vld", 128'(bus.out_valid), 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_idle_rdy", 128'(bus.in_ready), 1);
    chk("bp_beats",    128'(bus.out_beats), 0);

    // out_ready high before DONE
    bus.out_ready = 1'b1;
    send_beat(fill(7), fill(1), 1'b1);
    wait_out(lat);
    chk("e_lat",  128'(lat), 3);
    chk("e_outc", bus.out_c, fill(7));
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("e_vld", 128'(bus.out_valid), 0);

    // reset in WAIT of beat 2
    send_beat(fill(1), fill(1), 1'b0);
    send_beat(fill(1), fill(1), 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("r_outc",  bus.out_c, 0);
    chk("r_maca",  bus.mac_a, 0);
    chk("r_beats", 128'(bus.out_beats), 0);
    chk("r_rdy",   128'(bus.in_ready), 0);
    chk("r_vld",   128'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_beat(fill(2), fill(3), 1'b1);
    wait_out(lat);
    chk("r2_outc",  bus.out_c, fill(6));
    chk("r2_beats", 128'(bus.out_beats), 1);
    pop();

    // bias load on the first beat
`ifdef VMAC_BIAS_EN
    bus.in_bias = fill(5);
`endif
    send_beat(fill(1), fill(1), 1'b1);
    wait_out(lat);
`ifdef VMAC_BIAS_EN
    chk("b_outc", bus.out_c, fill(6));
`else
    chk("b_outc", bus.out_c, fill(1));
`endif
    chk("b_beats", 128'(bus.out_beats), 1);
    pop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
